uart_param_loader: RTL and testbench
====================================

// Module: uart_param_loader
// PURPOSE
//  Upstream stage of the pulse generator. Receives 8N1 UART frames on rxd in the 12 MHz clk domain.
//  Parses a fixed binary parameter frame and checks it.
//  Presents per/p1wid/del/p2wid/cp/bl as registered, atomically updated outputs.
//  These outputs feed the pulse generator's parameter inputs directly.
// PARAMETERS
//  CLK_HZ      12000000  system clock frequency
//  BAUD        115200    line rate; DIV = CLK_HZ/BAUD (integer, truncated; 104 at defaults)
//  TIMEOUT_CYC 120000    idle clocks allowed between bytes inside a frame (10 ms)
//  ST_PER      392       reset value of per (100500>>8)
//  ST_P1       30        reset value of p1wid
//  ST_DEL      200       reset value of del
//  ST_P2       30        reset value of p2wid
//  ST_CP       1         reset value of cp
//  ST_BL       1         reset value of bl
// PORTS
//  clk       in   1   12 MHz system clock, single clock domain
//  reset_n   in   1   asynchronous, active-low reset
//  rxd       in   1   UART receive line, asynchronous, idle high
//  per       out  24  period word (downstream shifts it <<8)
//  p1wid     out  16  first pulse width, PLL ticks
//  del       out  16  inter-pulse delay, PLL ticks
//  p2wid     out  16  second pulse width, PLL ticks
//  cp        out  1   pulsed(1)/CW(0) select
//  bl        out  1   blocking enable
//  load      out  1   1-clk strobe: new parameter set committed
//  frame_err out  1   1-clk strobe: frame discarded (bad stop bit, checksum, or timeout)
//  busy      out  1   high while the parser is outside HUNT
// BEHAVIOUR
//  Reset: per..bl = ST_* values; load, frame_err, busy = 0; parser in HUNT; UART RX idle.
//  Reset asserted mid-frame: partial frame is discarded and outputs return to ST_* values.
//  RX front end:
//   - rxd passes through a 2-flop synchronizer, with flops resetting to 1.
//   - A falling edge while idle starts a DIV/2 count; the start bit is re-sampled there.
//   - If the start bit is high on re-sample, it is a glitch: return to idle with no error.
//   - 8 data bits are sampled LSB first, every DIV clocks. The stop bit is sampled DIV clocks later.
//   - Stop bit = 1: byte_valid pulses for 1 clk. Stop bit = 0: rx_ferr pulses for 1 clk.
//   - RX re-arms on the clock after the stop sample; back-to-back bytes are supported.
//  Frame format: 0xA5, then 10 payload bytes, then 1 check byte.
//   - Payload is big-endian: per[23:0] (3 bytes), p1wid (2), del (2), p2wid (2), flags (1).
//   - Flags: bit0 = cp, bit1 = bl; bits 7:2 are ignored.
//   - Check byte = XOR of the 10 payload bytes.
//  Parser FSM: HUNT -> PAYLOAD(idx 0..9) -> CHECK -> HUNT.
//   - HUNT: non-0xA5 bytes are dropped silently. 0xA5 -> PAYLOAD, idx=0, xor=0.
//   - PAYLOAD: each byte goes into a shadow register at idx, and xor ^= byte.
//     0xA5 inside the payload is data, not a resync. After idx 9 -> CHECK.
//   - CHECK, byte == xor: shadow registers copy into the outputs on the same edge that raises load.
//     Go to HUNT.
//   - CHECK, byte != xor: frame_err = 1, outputs held, go to HUNT.
//  Latency: load rises on the clk after the check byte's stop-bit sample (byte_valid+1).
//  Outputs change only on a load edge, so the downstream stage never sees a mixed set.
//  rx_ferr outside HUNT: frame_err, go to HUNT. In HUNT, rx_ferr is ignored.
//  Timeout: idle counter (17 bits) clears on every byte_valid and counts only outside HUNT.
//   - Counter reaches TIMEOUT_CYC: frame_err, go to HUNT, counter cleared.
//   - Timeout and byte_valid on the same clk: the byte wins and the counter clears.
//  load and frame_err are never high together. busy = (state != HUNT).
//  No range checking of values: per=0 or widths >= period pass through unchanged.
// STRUCTURE
//  Shared package (pulses_pkg): SYNC_BYTE=8'hA5, PAYLOAD_LEN=10, parser state enum,
//   ST_* defaults shared with the pulse generator.
//  Sub-module uart_rx (clk, reset_n, rxd -> data[7:0], byte_valid, rx_ferr): synchronizer + bit timing.
//  Top level: parser FSM, shadow registers, XOR accumulator, timeout counter, output registers.
// TESTING
//  1 Reset, then idle -> per=392, p1wid=30, del=200, p2wid=30, cp=1, bl=1; load=0.
//  2 Send A5 00 01 00 | 00 32 | 01 F4 | 00 28 | 03 | check=XOR
//    -> single load pulse; per=0x000100, p1wid=50, del=500, p2wid=40, cp=1, bl=1.
//  3 Same frame with check byte ^0x01 -> frame_err pulse, no load, outputs unchanged.
//  4 Send 0x13 0xA5, then 4 payload bytes, then a 12 ms gap
//    -> frame_err at TIMEOUT_CYC after last byte; the next full frame loads normally.
//  5 Payload containing 0xA5 bytes, and byte with stop bit forced 0 mid-frame
//    -> first case loads correctly; second gives frame_err and parser returns to HUNT.
//  6 reset_n pulsed low during byte 6 -> outputs = ST_*, busy=0; 1-clk rxd low glitch gives no byte.

Source files
------------

// File: rtl/pulses_pkg.sv
// pulses_pkg: constants shared by the UART parameter loader and the pulse generator.
package pulses_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int PAYLOAD_LEN = 10;
  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [23:0] ST_PER = 24'd392;
  localparam logic [15:0] ST_P1 = 16'd30;
  localparam logic [15:0] ST_DEL = 16'd200;
  localparam logic [15:0] ST_P2 = 16'd30;
  localparam logic ST_CP = 1'b1;
  localparam logic ST_BL = 1'b1;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchronizer, mid-bit sampling and start-glitch rejection.
module uart_rx #(
  parameter int DIV = 104
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       rx_ferr
);
  localparam int CW = $clog2(DIV);
  logic s1, s2, prev, busy;
  logic [CW-1:0] cnt;
  logic [3:0] bit_idx;
  logic [7:0] sh;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {s1, s2, prev} <= 3'b111;
      busy <= 1'b0;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      data <= '0;
      byte_valid <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      {s1, s2, prev} <= {rxd, s1, s2};
      byte_valid <= 1'b0;
      rx_ferr <= 1'b0;
      if (!busy) begin
        if (prev && !s2) begin
          busy <= 1'b1;
          cnt <= CW'(DIV / 2 - 1);
          bit_idx <= '0;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else begin
        cnt <= CW'(DIV - 1);
        bit_idx <= bit_idx + 4'd1;
        // bit 0 is the start re-sample: a high line means it was a glitch
        if (bit_idx == 4'd0) busy <= !s2;
        else if (bit_idx < 4'd9) sh <= {s2, sh[7:1]};
        else begin
          busy <= 1'b0;
          data <= sh;
          byte_valid <= s2;
          rx_ferr <= !s2;
        end
      end
    end
endmodule

// File: rtl/uart_param_loader.sv
// uart_param_loader: parses checked UART parameter frames and commits them atomically
// to the pulse generator parameter outputs.
module uart_param_loader #(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD = 115200,
  parameter int TIMEOUT_CYC = 120000,
  parameter logic [23:0] ST_PER = pulses_pkg::ST_PER,
  parameter logic [15:0] ST_P1 = pulses_pkg::ST_P1,
  parameter logic [15:0] ST_DEL = pulses_pkg::ST_DEL,
  parameter logic [15:0] ST_P2 = pulses_pkg::ST_P2,
  parameter logic ST_CP = pulses_pkg::ST_CP,
  parameter logic ST_BL = pulses_pkg::ST_BL
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rxd,
  output logic [23:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic        cp,
  output logic        bl,
  output logic        load,
  output logic        frame_err,
  output logic        busy
);
  import pulses_pkg::*;
  localparam int DIV = CLK_HZ / BAUD;
  localparam logic [3:0] LAST = 4'(PAYLOAD_LEN - 1);
  logic [7:0] data, xacc;
  logic byte_valid, rx_ferr, timeout;
  logic [1:0] state, flags;
  logic [3:0] idx;
  logic [71:0] shadow;
  logic [16:0] tcnt;
  uart_rx #(.DIV(DIV)) u_rx (
    .clk(clk),
    .reset_n(reset_n),
    .rxd(rxd),
    .data(data),
    .byte_valid(byte_valid),
    .rx_ferr(rx_ferr)
  );
  assign timeout = tcnt == 17'(TIMEOUT_CYC);
  assign busy = state != HUNT;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= HUNT;
      idx <= '0;
      xacc <= '0;
      shadow <= '0;
      flags <= '0;
      tcnt <= '0;
      {per, p1wid, del, p2wid, cp, bl} <= {ST_PER, ST_P1, ST_DEL, ST_P2, ST_CP, ST_BL};
      load <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      load <= 1'b0;
      frame_err <= 1'b0;
      // a byte arriving on the timeout clock still clears the counter and is kept
      tcnt <= (state == HUNT || byte_valid || timeout) ? '0 : tcnt + 17'd1;
      if (byte_valid) begin
        if (state == HUNT && data == SYNC_BYTE) begin
          state <= PAYLOAD;
          idx <= '0;
          xacc <= '0;
        end else if (state == PAYLOAD) begin
          xacc <= xacc ^ data;
          idx <= idx + 4'd1;
          if (idx == LAST) begin
            flags <= data[1:0];
            state <= CHECK;
          end else shadow <= {shadow[63:0], data};
        end else if (state == CHECK) begin
          state <= HUNT;
          load <= data == xacc;
          frame_err <= data != xacc;
          if (data == xacc) {per, p1wid, del, p2wid, cp, bl} <= {shadow, flags[0], flags[1]};
        end
      end else if (state != HUNT && (rx_ferr || timeout)) begin
        frame_err <= 1'b1;
        state <= HUNT;
      end
    end
endmodule

// File: tb/tb_uart_param_loader.sv
// tb_uart_param_loader: directed frames against a scoreboard of expected commits and frame errors.
module tb_uart_param_loader;
  localparam int CLK_HZ = 12000000;
  localparam int BAUD = 1000000;
  localparam int DIV = CLK_HZ / BAUD;
  localparam int TO = 2000;
  typedef logic [7:0] frame_t[10];
  typedef struct packed {
    logic [23:0] per;
    logic [15:0] p1, dl, p2;
    logic cp, bl;
  } pset_t;
  typedef struct packed {
    logic is_load;
    pset_t p;
  } ev_t;
  localparam pset_t DEF = '{24'd392, 16'd30, 16'd200, 16'd30, 1'b1, 1'b1};
  logic clk = 1'b0, reset_n = 1'b0, rxd = 1'b1;
  logic [23:0] per;
  logic [15:0] p1wid, del, p2wid;
  logic cp, bl, load, frame_err, busy;
  ev_t expq[$];
  pset_t cur = DEF;
  int checks = 0, errors = 0, cyc = 0, err_cyc = 0;
  uart_param_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .rxd(rxd), .per(per), .p1wid(p1wid), .del(del),
    .p2wid(p2wid), .cp(cp), .bl(bl), .load(load), .frame_err(frame_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input logic [79:0] a, input logic [79:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge clk) begin
    pset_t got;
    got = '{per, p1wid, del, p2wid, cp, bl};
    if (!reset_n) begin
      cur = DEF;
      expq.delete();
      chk("reset_strobes", {load, frame_err, busy}, 3'b000);
    end else begin
      if (load || frame_err) begin
        checks++;
        if (load && frame_err) begin
          errors++;
          $display("FAIL strobe_clash: load and frame_err both high at cycle %0d", cyc);
        end else if (expq.size() == 0 || expq[0].is_load != load) begin
          errors++;
          $display("FAIL strobe: got load=%0b frame_err=%0b, expected none at cycle %0d", load, frame_err, cyc);
        end else begin
          if (load) cur = expq[0].p;
          void'(expq.pop_front());
        end
        if (frame_err) err_cyc = cyc;
      end
    end
    chk("outputs", got, cur);
  end
  function automatic pset_t decode(input frame_t p);
    return '{{p[0], p[1], p[2]}, {p[3], p[4]}, {p[5], p[6]}, {p[7], p[8]}, p[9][0], p[9][1]};
  endfunction
  task automatic hold(input logic v);
    rxd = v;
    repeat (DIV) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    hold(1'b0);
    for (int i = 0; i < 8; i++) hold(b[i]);
    hold(stop);
    rxd = 1'b1;
  endtask
  task automatic expect_ev(input logic is_load, input pset_t p);
    ev_t e;
    e.is_load = is_load;
    e.p = p;
    expq.push_back(e);
  endtask
  task automatic drained(input string n);
    @(negedge clk);
    chk(n, 80'(expq.size()), 80'd0);
  endtask
  task automatic send_frame(input frame_t p, input logic [7:0] flip);
    logic [7:0] x;
    x = 8'h00;
    foreach (p[i]) x ^= p[i];
    expect_ev(flip == 8'h00, decode(p));
    send_byte(8'hA5);
    foreach (p[i]) send_byte(p[i]);
    send_byte(x ^ flip);
    drained("frame_latency");
    repeat (DIV) @(posedge clk);
    #1;
  endtask
  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end
  initial begin
    frame_t f2, f5, f5b;
    int c0;
    f2 = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h32, 8'h01, 8'hF4, 8'h00, 8'h28, 8'h03};
    f5 = '{8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'h00, 8'h10, 8'h12, 8'h34, 8'hA5};
    f5b = '{8'h12, 8'h34, 8'h56, 8'h00, 8'h07, 8'h00, 8'h08, 8'h00, 8'h09, 8'hFE};
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rst_per", per, 392);
    chk("rst_p1", p1wid, 30);
    chk("rst_del", del, 200);
    chk("rst_p2", p2wid, 30);
    chk("rst_cp_bl", {cp, bl}, 2'b11);
    chk("rst_load_busy", {load, busy}, 2'b00);
    #1;
    send_frame(f2, 8'h00);
    chk("t2_per", per, 24'h000100);
    chk("t2_p1", p1wid, 50);
    chk("t2_del", del, 500);
    chk("t2_p2", p2wid, 40);
    chk("t2_cp_bl", {cp, bl}, 2'b11);
    send_frame(f2, 8'h01);
    chk("t3_per_held", per, 24'h000100);
    send_byte(8'h13);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_byte(f5b[i]);
    c0 = cyc;
    expect_ev(1'b0, DEF);
    @(negedge clk);
    chk("t4_busy_gap", busy, 1'b1);
    for (int i = 0; i < TO + 4 * DIV && expq.size() != 0; i++) @(posedge clk);
    drained("t4_timeout_seen");
    chk("t4_timeout_window", 80'((err_cyc - c0 >= TO - DIV) && (err_cyc - c0 <= TO + DIV)), 80'd1);
    chk("t4_busy_after", busy, 1'b0);
    #1;
    send_frame(f5, 8'h00);
    chk("t5_per", per, 24'hA5A500);
    chk("t5_p1", p1wid, 16'hA5A5);
    chk("t5_del", del, 16'h0010);
    chk("t5_p2", p2wid, 16'h1234);
    chk("t5_cp_bl", {cp, bl}, 2'b10);
    send_byte(8'hA5);
    send_byte(8'h11);
    send_byte(8'h22);
    expect_ev(1'b0, DEF);
    send_byte(8'h33, 1'b0);
    drained("t5_stop_err");
    chk("t5_busy_hunt", busy, 1'b0);
    repeat (DIV) @(posedge clk);
    #1;
    send_frame(f5b, 8'h00);
    chk("t5b_per", per, 24'h123456);
    chk("t5b_cp_bl", {cp, bl}, 2'b01);
    send_byte(8'hA5);
    for (int i = 0; i < 5; i++) send_byte(f2[i]);
    fork
      send_byte(8'hFF);
      begin
        repeat (3 * DIV) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_per", per, 392);
        chk("t6_rst_busy", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
      end
    join
    repeat (2 * DIV) @(posedge clk);
    #1 rxd = 1'b0;
    @(posedge clk);
    #1 rxd = 1'b1;
    repeat (3 * DIV) @(posedge clk);
    @(negedge clk);
    chk("t6_glitch_busy", busy, 1'b0);
    chk("t6_glitch_p2", p2wid, 30);
    #1;
    send_frame(f2, 8'h00);
    chk("t6_reload_del", del, 500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
